// File: rtl/wishbone_mem_arbiter.sv
// wishbone_mem_arbiter
//   Two-master Wishbone arbiter feeding a single memory interconnect port.
//   Round-robin between m0 and m1; a grant is held for the whole cyc window
//   and handed straight to a waiting master with no idle bubble. Only the
//   granted master sees ack/read data; interrupt is broadcast to both.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   A watchdog that completes a strobe locally with ack and all-ones data
//   after TIMEOUT unacknowledged strobe cycles, pulsing o_timeout.
//   Without the macro, o_timeout is tied low and strobes wait indefinitely.
//
// Parameters:
//   TIMEOUT       cycles of unacknowledged o_mem_stb before the watchdog fires (2..65535)
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   i_m0_*, o_m0_*  master 0 request (we/stb/cyc/sel/adr/dat) and response (dat/ack/int)
//   i_m1_*, o_m1_*  master 1, same set
//   o_mem_*       request to the memory interconnect
//   i_mem_*       response from the memory interconnect (dat/ack/int)
//   o_timeout     one-cycle pulse when the watchdog fires
module wishbone_mem_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m0_we,
    input  logic        i_m0_stb,
    input  logic        i_m0_cyc,
    input  logic [3:0]  i_m0_sel,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    output logic [31:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_int,
    input  logic        i_m1_we,
    input  logic        i_m1_stb,
    input  logic        i_m1_cyc,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    output logic [31:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_int,
    output logic        o_mem_we,
    output logic        o_mem_stb,
    output logic        o_mem_cyc,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic [31:0] i_mem_dat,
    input  logic        i_mem_ack,
    input  logic        i_mem_int,
    output logic        o_timeout
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
        $error("wishbone_mem_arbiter: TIMEOUT must be in 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   timeout_hit;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    // tie: favour the master that was not served last
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (i_m0_cyc) begin
                    state_d = GRANT0;
                end else if (i_m1_cyc) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!i_m0_cyc) begin
                    last_d  = 1'b0;
                    state_d = i_m1_cyc ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!i_m1_cyc) begin
                    last_d  = 1'b1;
                    state_d = i_m0_cyc ? GRANT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    // Counter clears on ack, idle strobe or grant change; on the last count the
    // following cycle becomes the timeout cycle (o_mem_stb is masked then, so the
    // counter restarts from zero automatically).
    always_comb begin
        cnt_d = '0;
        to_d  = 1'b0;
        if (state_d == state_q && o_mem_stb && !i_mem_ack) begin
            if (cnt_q == CNT_LAST) begin
                to_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign timeout_hit = to_q;
`else
    assign timeout_hit = 1'b0;
`endif

    assign o_timeout = timeout_hit;

    // Output logic: request mux and response routing from the current grant
    always_comb begin
        o_mem_we  = 1'b0;
        o_mem_stb = 1'b0;
        o_mem_cyc = 1'b0;
        o_mem_sel = '0;
        o_mem_adr = '0;
        o_mem_dat = '0;
        o_m0_ack  = 1'b0;
        o_m0_dat  = '0;
        o_m1_ack  = 1'b0;
        o_m1_dat  = '0;
        o_m0_int  = i_mem_int;
        o_m1_int  = i_mem_int;
        case (state_q)
            GRANT0: begin
                o_mem_we  = i_m0_we;
                o_mem_stb = i_m0_stb & ~timeout_hit;
                o_mem_cyc = i_m0_cyc;
                o_mem_sel = i_m0_sel;
                o_mem_adr = i_m0_adr;
                o_mem_dat = i_m0_dat;
                o_m0_ack  = timeout_hit | i_mem_ack;
                o_m0_dat  = timeout_hit ? '1 : i_mem_dat;
            end
            GRANT1: begin
                o_mem_we  = i_m1_we;
                o_mem_stb = i_m1_stb & ~timeout_hit;
                o_mem_cyc = i_m1_cyc;
                o_mem_sel = i_m1_sel;
                o_mem_adr = i_m1_adr;
                o_mem_dat = i_m1_dat;
                o_m1_ack  = timeout_hit | i_mem_ack;
                o_m1_dat  = timeout_hit ? '1 : i_mem_dat;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_mem_arbiter.sv
// tb_wishbone_mem_arbiter
//   Directed bench for wishbone_mem_arbiter: reset values, single-master read,
//   idle ack drop, interrupt passthrough, async reset mid-write, tie after
//   reset with gapless handover, round-robin fairness and the watchdog
//   (or its absence in the default build).
module tb_wishbone_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic        clk;
    logic        rst;
    logic        m0_we, m0_stb, m0_cyc;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_dat_w;
    logic [31:0] m0_dat_r;
    logic        m0_ack, m0_int;
    logic        m1_we, m1_stb, m1_cyc;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_dat_w;
    logic [31:0] m1_dat_r;
    logic        m1_ack, m1_int;
    logic        mem_we, mem_stb, mem_cyc;
    logic [3:0]  mem_sel;
    logic [31:0] mem_adr, mem_dat_w;
    logic [31:0] mem_dat_r;
    logic        mem_ack, mem_int;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    wishbone_mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_m0_we   (m0_we),
        .i_m0_stb  (m0_stb),
        .i_m0_cyc  (m0_cyc),
        .i_m0_sel  (m0_sel),
        .i_m0_adr  (m0_adr),
        .i_m0_dat  (m0_dat_w),
        .o_m0_dat  (m0_dat_r),
        .o_m0_ack  (m0_ack),
        .o_m0_int  (m0_int),
        .i_m1_we   (m1_we),
        .i_m1_stb  (m1_stb),
        .i_m1_cyc  (m1_cyc),
        .i_m1_sel  (m1_sel),
        .i_m1_adr  (m1_adr),
        .i_m1_dat  (m1_dat_w),
        .o_m1_dat  (m1_dat_r),
        .o_m1_ack  (m1_ack),
        .o_m1_int  (m1_int),
        .o_mem_we  (mem_we),
        .o_mem_stb (mem_stb),
        .o_mem_cyc (mem_cyc),
        .o_mem_sel (mem_sel),
        .o_mem_adr (mem_adr),
        .o_mem_dat (mem_dat_w),
        .i_mem_dat (mem_dat_r),
        .i_mem_ack (mem_ack),
        .i_mem_int (mem_int),
        .o_timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; drives and checks happen away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        m0_we = 0; m0_stb = 0; m0_cyc = 0; m0_sel = '0; m0_adr = '0; m0_dat_w = '0;
        m1_we = 0; m1_stb = 0; m1_cyc = 0; m1_sel = '0; m1_adr = '0; m1_dat_w = '0;
        mem_dat_r = '0; mem_ack = 0; mem_int = 0;

        // reset values
        #1;
        chk("rst_mem_cyc", mem_cyc, 0);
        chk("rst_mem_stb", mem_stb, 0);
        chk("rst_mem_we",  mem_we, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_m0_ack",  m0_ack, 0);
        chk("rst_m1_ack",  m1_ack, 0);
        chk("rst_m0_dat",  m0_dat_r, 0);
        chk("rst_timeout", timeout, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // single master read at 0x10, ack after 3 cycles
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_adr = 32'h0000_0010;
        #1;
        chk("grant_latency_cyc", mem_cyc, 0);
        tick();
        #1;
        chk("rd_mem_cyc", mem_cyc, 1);
        chk("rd_mem_stb", mem_stb, 1);
        chk("rd_mem_adr", mem_adr, 32'h0000_0010);
        chk("rd_mem_sel", mem_sel, 4'hF);
        chk("rd_m0_ack_pre", m0_ack, 0);
        tick();
        tick();
        mem_ack = 1; mem_dat_r = 32'hDEAD_BEEF;
        #1;
        chk("rd_m0_ack", m0_ack, 1);
        chk("rd_m0_dat", m0_dat_r, 32'hDEAD_BEEF);
        chk("rd_m1_ack", m1_ack, 0);
        chk("rd_m1_dat", m1_dat_r, 0);
        tick();
        mem_ack = 0; mem_dat_r = '0; m0_cyc = 0; m0_stb = 0;
        tick();
        #1;
        chk("rd_back_idle", mem_cyc, 0);

        // ack in idle is dropped; interrupt passes through
        mem_ack = 1; mem_dat_r = 32'h1111_2222; mem_int = 1;
        #1;
        chk("idle_m0_ack", m0_ack, 0);
        chk("idle_m1_ack", m1_ack, 0);
        chk("idle_m0_dat", m0_dat_r, 0);
        chk("int_m0", m0_int, 1);
        chk("int_m1", m1_int, 1);
        mem_ack = 0; mem_dat_r = '0; mem_int = 0;
        #1;
        chk("int_m0_low", m0_int, 0);

        // async reset while m1 writes (last is 0 here, so reset must restore it)
        tick();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3;
        m1_adr = 32'h2000_0004; m1_dat_w = 32'h1234_5678;
        tick();
        mem_ack = 1; mem_dat_r = 32'h0BAD_F00D;
        #1;
        chk("wr_mem_stb", mem_stb, 1);
        chk("wr_mem_we",  mem_we, 1);
        chk("wr_mem_dat", mem_dat_w, 32'h1234_5678);
        chk("wr_mem_adr", mem_adr, 32'h2000_0004);
        chk("wr_m1_ack",  m1_ack, 1);
        rst = 1'b0;
        #1;
        chk("arst_mem_cyc", mem_cyc, 0);
        chk("arst_mem_stb", mem_stb, 0);
        chk("arst_m1_ack",  m1_ack, 0);
        m1_cyc = 0; m1_stb = 0; m1_we = 0; mem_ack = 0; mem_dat_r = '0;
        tick();
        rst = 1'b1;
        tick();

        // tie right after reset -> m0, then gapless handover to m1
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200; m1_we = 0;
        tick();
        #1;
        chk("tie_first_m0", mem_adr, 32'h0000_0100);
        m0_cyc = 0; m0_stb = 0;
        tick();
        #1;
        chk("handover_adr", mem_adr, 32'h0000_0200);
        chk("handover_cyc", mem_cyc, 1);
        mem_ack = 1; mem_dat_r = 32'hCAFE_F00D;
        #1;
        chk("m1_ack", m1_ack, 1);
        chk("m1_dat", m1_dat_r, 32'hCAFE_F00D);
        chk("m1_other_ack", m0_ack, 0);
        chk("m1_other_dat", m0_dat_r, 0);
        mem_ack = 0; mem_dat_r = '0;
        m1_cyc = 0; m1_stb = 0;
        tick();
        #1;
        chk("tie_end_idle", mem_cyc, 0);

        // fairness: both keep requesting, each drops cyc for one cycle after its turn
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 1; m1_stb = 1;
        mem_ack = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            chk($sformatf("rr_adr_%0d", i), mem_adr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            chk($sformatf("rr_m0_ack_%0d", i), m0_ack, (i % 2 == 0) ? 1 : 0);
            if (i == 7) begin
                m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            end else if (i % 2 == 0) begin
                m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1;
            end else begin
                m0_cyc = 1; m0_stb = 1; m1_cyc = 0; m1_stb = 0;
            end
        end
        mem_ack = 0;
        tick();
        #1;
        chk("rr_end_idle", mem_cyc, 0);

        // watchdog: m0 strobes, memory never acks
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0300;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("wd_wait_stb_%0d", k), mem_stb, 1);
            chk($sformatf("wd_wait_to_%0d", k), timeout, 0);
            chk($sformatf("wd_wait_ack_%0d", k), m0_ack, 0);
            tick();
        end
        mem_ack = 1; mem_dat_r = 32'h5555_5555;
        #1;
        chk("wd_m0_ack", m0_ack, 1);
        chk("wd_m0_dat", m0_dat_r, 32'hFFFF_FFFF);
        chk("wd_timeout", timeout, 1);
        chk("wd_mem_stb", mem_stb, 0);
        chk("wd_mem_cyc", mem_cyc, 1);
        chk("wd_m1_ack", m1_ack, 0);
        tick();
        mem_ack = 0; mem_dat_r = '0;
        #1;
        chk("wd_after_to", timeout, 0);
        chk("wd_after_stb", mem_stb, 1);
`else
        for (int k = 0; k < 20; k++) begin
            #1;
            chk($sformatf("nowd_stb_%0d", k), mem_stb, 1);
            chk($sformatf("nowd_to_%0d", k), timeout, 0);
            chk($sformatf("nowd_ack_%0d", k), m0_ack, 0);
            tick();
        end
`endif
        m0_cyc = 0; m0_stb = 0;
        tick();
        #1;
        chk("final_idle", mem_cyc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
